// File: rtl/gcn_aggregation.sv
// -----------------------------------------------------------------------------
// gcn_aggregation
//   Combination stage of the GCN datapath. Takes the transformed matrix
//   FM*WM, seeds the per-node aggregate with it (self-loop term), then walks
//   the COO edge list one column per cycle. Each legal edge (s,d), s != d,
//   adds row d into aggregate row s and row s into aggregate row d. done is
//   raised when the walk finishes and is held until start is released.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        level; FM*WM valid and stable while high
//   fm_wm_in     FEATURE_ROWS x WEIGHT_COLS words of DOT_PROD_WIDTH bits
//   coo_in       {src, dst} node indices (1-based), combinational response
//                to coo_address
//   coo_address  edge column currently being read
//   done         aggregate valid
//   agg_out      registered aggregate, same shape as fm_wm_in
// -----------------------------------------------------------------------------
module gcn_aggregation #(
   parameter int FEATURE_ROWS    = 6,
   parameter int WEIGHT_COLS     = 3,
   parameter int DOT_PROD_WIDTH  = 16,
   parameter int NUM_OF_NODES    = 6,
   parameter int COO_NUM_OF_COLS = 6,
   parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
   input  logic                                                       clk,
   input  logic                                                       reset,
   input  logic                                                       start,
   input  logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] fm_wm_in,
   input  logic [2*COO_BW-1:0]                                        coo_in,
   output logic [COO_BW-1:0]                                          coo_address,
   output logic                                                       done,
   output logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] agg_out
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_INIT = 2'd1;
   localparam logic [1:0] S_EDGE = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [COO_BW-1:0] MAX_NODE  = COO_BW'(NUM_OF_NODES);
   localparam logic [COO_BW-1:0] LAST_EDGE = COO_BW'(COO_NUM_OF_COLS - 1);

   logic [1:0]        state;
   logic [COO_BW-1:0] edge_cnt;

   logic [COO_BW-1:0] src;
   logic [COO_BW-1:0] dst;
   logic [COO_BW-1:0] src_idx;
   logic [COO_BW-1:0] dst_idx;
   logic              edge_valid;

   logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]                      fm_src_row;
   logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]                      fm_dst_row;
   logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]    agg_next;

   // The edge counter is the read address itself.
   assign coo_address = edge_cnt;

   assign src     = coo_in[2*COO_BW-1:COO_BW];
   assign dst     = coo_in[COO_BW-1:0];
   assign src_idx = src - 1'b1;
   assign dst_idx = dst - 1'b1;

   // Index 0 and anything above the node count are padding; s == d is the
   // self-loop, which the INIT seed already covers.
   assign edge_valid = (src != '0) && (dst != '0) &&
                       (src <= MAX_NODE) && (dst <= MAX_NODE) &&
                       (src != dst);

   // Row fetch by compare-and-select so out-of-range indices never address
   // past the matrix.
   always_comb begin
      fm_src_row = '0;
      fm_dst_row = '0;
      for (int unsigned i = 0; i < FEATURE_ROWS; i++) begin
         if (src_idx == COO_BW'(i)) fm_src_row = fm_wm_in[i];
         if (dst_idx == COO_BW'(i)) fm_dst_row = fm_wm_in[i];
      end
   end

   // Because s != d, no row can receive both contributions in one cycle.
   always_comb begin
      agg_next = agg_out;
      if (edge_valid) begin
         for (int unsigned i = 0; i < FEATURE_ROWS; i++) begin
            for (int unsigned j = 0; j < WEIGHT_COLS; j++) begin
               if (src_idx == COO_BW'(i))
                  agg_next[i][j] = agg_out[i][j] + fm_dst_row[j];
               else if (dst_idx == COO_BW'(i))
                  agg_next[i][j] = agg_out[i][j] + fm_src_row[j];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         edge_cnt <= '0;
         done     <= 1'b0;
         agg_out  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) state <= S_INIT;
            end
            S_INIT: begin
               agg_out  <= fm_wm_in;
               edge_cnt <= '0;
               state    <= S_EDGE;
            end
            S_EDGE: begin
               agg_out <= agg_next;
               if (edge_cnt == LAST_EDGE) begin
                  edge_cnt <= '0;
                  done     <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  edge_cnt <= edge_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (!start) begin
                  done  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcn_aggregation.sv
// -----------------------------------------------------------------------------
// tb_gcn_aggregation
//   Table of edge lists / FM*WM matrices with hand-derived aggregates, applied
//   in a loop through a scoreboard queue, plus hand-written sequences for
//   asynchronous reset, reset in the middle of the edge walk, and DONE hold.
// -----------------------------------------------------------------------------
module tb_gcn_aggregation;

   localparam int FR = 6;
   localparam int WC = 3;
   localparam int DW = 16;
   localparam int NV = 5;

   typedef logic [FR-1:0][WC-1:0][DW-1:0] mat_t;

   typedef struct packed {
      logic [5:0][5:0] edges;
      mat_t            fm;
      mat_t            expv;
   } vec_t;

   logic                 clk;
   logic                 reset;
   logic                 start;
   mat_t                 fm_wm_in;
   logic [5:0]           coo_in;
   logic [2:0]           coo_address;
   logic                 done;
   mat_t                 agg_out;

   logic [7:0][5:0]      cur_edges;
   vec_t                 vecs [NV];
   string                vnames [NV];
   mat_t                 exp_q [$];

   int total = 0;
   int bad   = 0;

   gcn_aggregation #(
      .FEATURE_ROWS   (FR),
      .WEIGHT_COLS    (WC),
      .DOT_PROD_WIDTH (DW),
      .NUM_OF_NODES   (6),
      .COO_NUM_OF_COLS(6)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .fm_wm_in   (fm_wm_in),
      .coo_in     (coo_in),
      .coo_address(coo_address),
      .done       (done),
      .agg_out    (agg_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge-list memory answers combinationally, like the upstream COO store.
   always_comb coo_in = cur_edges[coo_address];

   function automatic logic [5:0] ed(input int s, input int d);
      logic [2:0] sv;
      logic [2:0] dv;
      sv = s[2:0];
      dv = d[2:0];
      return {sv, dv};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic chk_mat(input string nm, input mat_t act, input mat_t want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   task automatic chk_words(input string nm, input mat_t want);
      for (int i = 0; i < FR; i++)
         for (int j = 0; j < WC; j++)
            chk($sformatf("%s agg r%0d c%0d", nm, i + 1, j),
                32'(agg_out[i][j]), 32'(want[i][j]));
   endtask

   task automatic fill_vectors();
      for (int v = 0; v < NV; v++) begin
         vecs[v].edges = '0;
         vecs[v].fm    = '0;
         vecs[v].expv  = '0;
      end
      // ring, all ones: every node has two neighbours -> 3
      vnames[0] = "ring";
      vecs[0].edges[0] = ed(1, 2); vecs[0].edges[1] = ed(2, 3);
      vecs[0].edges[2] = ed(3, 4); vecs[0].edges[3] = ed(4, 5);
      vecs[0].edges[4] = ed(5, 6); vecs[0].edges[5] = ed(6, 1);
      for (int i = 0; i < FR; i++)
         for (int j = 0; j < WC; j++) begin
            vecs[0].fm[i][j]   = 16'd1;
            vecs[0].expv[i][j] = 16'd3;
         end
      // star centred on node 1 plus an illegal (0,3)
      vnames[1] = "star";
      vecs[1].edges[0] = ed(1, 2); vecs[1].edges[1] = ed(1, 3);
      vecs[1].edges[2] = ed(1, 4); vecs[1].edges[3] = ed(1, 5);
      vecs[1].edges[4] = ed(1, 6); vecs[1].edges[5] = ed(0, 3);
      for (int i = 0; i < FR; i++)
         for (int j = 0; j < WC; j++)
            vecs[1].fm[i][j] = 16'((i + 1) * (j + 1));
      vecs[1].expv[0][0] = 16'd21; vecs[1].expv[0][1] = 16'd42; vecs[1].expv[0][2] = 16'd63;
      for (int k = 2; k <= 6; k++)
         for (int j = 0; j < WC; j++)
            vecs[1].expv[k-1][j] = 16'((k + 1) * (j + 1));
      // self-loop and duplicate edge
      vnames[2] = "selfdup";
      vecs[2].edges[0] = ed(2, 2); vecs[2].edges[1] = ed(3, 4);
      vecs[2].edges[2] = ed(3, 4);
      vecs[2].fm[1][0] = 16'd7; vecs[2].fm[1][1] = 16'd8; vecs[2].fm[1][2] = 16'd9;
      vecs[2].fm[2][0] = 16'd10;
      vecs[2].fm[3][0] = 16'd5;
      vecs[2].expv[1][0] = 16'd7; vecs[2].expv[1][1] = 16'd8; vecs[2].expv[1][2] = 16'd9;
      vecs[2].expv[2][0] = 16'd20;
      vecs[2].expv[3][0] = 16'd25;
      // wrap modulo 2^16
      vnames[3] = "wrap";
      vecs[3].edges[0] = ed(1, 2);
      vecs[3].fm[0][0] = 16'hFFFF;
      vecs[3].fm[1][0] = 16'd2;
      vecs[3].expv[0][0] = 16'h0001;
      vecs[3].expv[1][0] = 16'h0001;
      // out-of-range indices, reversed duplicate, self-loop, zero index
      vnames[4] = "badidx";
      vecs[4].edges[0] = ed(7, 1); vecs[4].edges[1] = ed(1, 7);
      vecs[4].edges[2] = ed(2, 5); vecs[4].edges[3] = ed(5, 2);
      vecs[4].edges[4] = ed(6, 6); vecs[4].edges[5] = ed(3, 0);
      for (int i = 0; i < FR; i++) begin
         vecs[4].fm[i][0]   = 16'(10 * (i + 1));
         vecs[4].fm[i][1]   = 16'(i + 1);
         vecs[4].expv[i][0] = 16'(10 * (i + 1));
         vecs[4].expv[i][1] = 16'(i + 1);
      end
      vecs[4].expv[1][0] = 16'd120; vecs[4].expv[1][1] = 16'd12;
      vecs[4].expv[4][0] = 16'd90;  vecs[4].expv[4][1] = 16'd9;
   endtask

   // abort_addr >= 0: pull reset while coo_address shows that edge column.
   task automatic run(input int vi, input int abort_addr);
      int   k;
      bit   seen;
      mat_t e;
      fm_wm_in  = vecs[vi].fm;
      cur_edges = {12'h000, vecs[vi].edges};
      if (abort_addr < 0) exp_q.push_back(vecs[vi].expv);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      k    = 0;
      seen = 1'b0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (k >= 2 && k <= 7) begin
            chk($sformatf("%s coo_address k=%0d", vnames[vi], k - 2),
                32'(coo_address), 32'(k - 2));
            if (abort_addr == k - 2) begin
               reset = 1'b0;
               #1;
               chk("abort done", 32'(done), 32'd0);
               chk("abort coo_address", 32'(coo_address), 32'd0);
               chk_mat("abort agg_out", agg_out, '0);
               start = 1'b0;
               @(negedge clk);
               reset = 1'b1;
               repeat (3) @(negedge clk);
               chk("abort idle done", 32'(done), 32'd0);
               return;
            end
         end
         if (done) seen = 1'b1;
      end
      chk($sformatf("%s done latency", vnames[vi]), 32'(k), 32'd8);
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s scoreboard: got empty queue want entry", vnames[vi]);
      end else begin
         e = exp_q.pop_front();
         chk_words(vnames[vi], e);
         // DONE holds while start stays high
         repeat (2) @(negedge clk);
         chk($sformatf("%s hold done", vnames[vi]), 32'(done), 32'd1);
         chk($sformatf("%s hold coo_address", vnames[vi]), 32'(coo_address), 32'd0);
         chk_mat($sformatf("%s hold agg", vnames[vi]), agg_out, e);
         start = 1'b0;
         @(negedge clk);
         chk($sformatf("%s release done", vnames[vi]), 32'(done), 32'd0);
         // back in IDLE the aggregate stays put even if the input moves
         fm_wm_in = {FR * WC {16'hA5A5}};
         repeat (2) @(negedge clk);
         chk_mat($sformatf("%s idle agg", vnames[vi]), agg_out, e);
      end
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      fm_wm_in  = '0;
      cur_edges = '0;
      fill_vectors();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // asynchronous reset in mid-cycle, checked before any clock edge
      #3;
      reset = 1'b0;
      #1;
      chk("reset done", 32'(done), 32'd0);
      chk("reset coo_address", 32'(coo_address), 32'd0);
      chk_mat("reset agg_out", agg_out, '0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      for (int v = 0; v < NV; v++) run(v, -1);

      // reset while edge column 3 is being read, then a clean rerun
      run(0, 3);
      run(0, -1);

      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gcn_aggregation.md
Name: gcn_aggregation

Overview:
- Combination stage of the GCN datapath, directly downstream of the feature×weight transformation stage.
- Consumes the transformed matrix FM·WM (FEATURE_ROWS × WEIGHT_COLS words) and walks the COO edge list one column per cycle over the existing coo_address/coo_in interface.
- Accumulates neighbour rows into a per-node aggregate (self-loop included) and raises done for the downstream argmax stage.

Parameters:
- FEATURE_ROWS, 6, number of nodes / rows of FM·WM
- WEIGHT_COLS, 3, columns of FM·WM
- DOT_PROD_WIDTH, 16, width of every FM·WM and aggregate word
- NUM_OF_NODES, 6, highest legal node index
- COO_NUM_OF_COLS, 6, number of edges in the COO list
- COO_BW, $clog2(COO_NUM_OF_COLS), width of one COO node index and of coo_address

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  level; high = FM·WM input valid and stable
- fm_wm_in  in  [FEATURE_ROWS][WEIGHT_COLS]×DOT_PROD_WIDTH  transformed matrix; must stay stable while start is high
- coo_in  in  2*COO_BW  {src, dst}; src is the upper half; combinational response to coo_address in the same cycle
- coo_address  out  COO_BW  edge column being read
- done  out  1  aggregate valid
- agg_out  out  [FEATURE_ROWS][WEIGHT_COLS]×DOT_PROD_WIDTH  aggregated matrix, registered

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, coo_address=0, done=0, every agg_out word=0, edge counter=0.
- IDLE: start=1 -> INIT; otherwise hold.
- INIT (1 cycle): agg_out[i][j] <= fm_wm_in[i][j] for all i,j (self-loop term); coo_address <= 0; -> EDGE.
- EDGE (exactly COO_NUM_OF_COLS cycles, k=0..COO_NUM_OF_COLS-1): coo_address=k; sample coo_in in the same cycle.
  - Let s=src, d=dst (1-based node indices).
  - If 1≤s≤NUM_OF_NODES, 1≤d≤NUM_OF_NODES and s≠d: agg[s-1] += fm_wm_in[d-1] and agg[d-1] += fm_wm_in[s-1], element-wise, in one cycle.
  - If s==d (legal index): no update; the self-loop is already applied in INIT.
  - If s or d is 0 or >NUM_OF_NODES: edge skipped, no update.
  - Duplicate edges are accumulated again (no dedup).
  - coo_address increments after each edge.
  - After edge COO_NUM_OF_COLS-1: -> DONE, coo_address <= 0.
- DONE: done=1; agg_out frozen. start=0 -> IDLE, done <= 0 on that edge. start still high -> stay in DONE (no re-run).
- Arithmetic: unsigned addition, wrap modulo 2^DOT_PROD_WIDTH; no saturation, no overflow flag.
- Latency: start sampled high in IDLE at edge T -> INIT at T+1, EDGE over T+2..T+1+COO_NUM_OF_COLS, done=1 from T+2+COO_NUM_OF_COLS.
- start dropping mid-EDGE: ignored; the sequence completes. fm_wm_in must remain stable (protocol requirement, not checked).
- Reset mid-operation: immediate return to IDLE, all outputs cleared; the partial aggregate is discarded.
- agg_out updates only in INIT and EDGE. Values during EDGE are partial and are not valid until done=1.

Test Plan:
- Reset check: assert reset=0 at an arbitrary time -> done=0, coo_address=0, all agg_out=0 within the same timestep, before any clock edge.
- Ring of 6 edges (1,2)(2,3)(3,4)(4,5)(5,6)(6,1), all FM·WM words = 1 -> every agg_out word = 3. done rises exactly 8 cycles after start sampled. coo_address sequence during EDGE = 0,1,2,3,4,5.
- Star (1,2)(1,3)(1,4)(1,5)(1,6) plus invalid (0,3); FM·WM row i = {i,2i,3i} (1-based) -> row1 = {21,42,63}; row k≥2 = {k+1, 2(k+1), 3(k+1)}. The (0,3) edge contributes nothing.
- Self-loop and duplicate: edges (2,2)(3,4)(3,4), others 0; row3={10,0,0}, row4={5,0,0}, rest 0 -> agg row2 = input row2, row3={20,0,0}, row4={25,0,0}.
- Overflow wrap: row1={0xFFFF,0,0}, row2={2,0,0}, single edge (1,2) -> agg row1 word0 = 0x0001, row2 word0 = 0x0001.
- Reset during EDGE at k=3, then release and restart -> outputs cleared immediately. Rerun result identical to a clean run; done asserts only at the new T+8.
